// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper-motor phase sequencer.
// Contents: FSM state enum, rate code constants, full- and half-step coil
// tables, and a lookup helper that returns the coil pattern for a phase index.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        RUN  = 2'b10,
        DEAD = 2'b11
    } state_e;

    localparam logic [1:0] RATE_HOLD = 2'b00;
    localparam logic [1:0] RATE_1    = 2'b01;
    localparam logic [1:0] RATE_2    = 2'b10;
    localparam logic [1:0] RATE_3    = 2'b11;

    // Index 0 sits in the least-significant nibble.
    localparam logic [15:0] FULL_TBL = {4'b1001, 4'b1100, 4'b0110, 4'b0011};
    localparam logic [31:0] HALF_TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                        4'b0110, 4'b0010, 4'b0011, 4'b0001};

    // Coil pattern for a phase index; full-step uses only idx[1:0].
    function automatic logic [3:0] phase_coil(input logic half, input logic [2:0] idx);
        logic [3:0] c;
        if (half) begin
            c = HALF_TBL[{idx, 2'b00} +: 4];
        end else begin
            c = FULL_TBL[{idx[1:0], 2'b00} +: 4];
        end
        return c;
    endfunction

endpackage

// File: rtl/stepper_seq_step_timer.sv
// Loadable down-counter used for step periods and dead time.
// Ports: clk, reset_n (async active-low), clr (force to zero), load (take
// load_val), load_val, tc (count is zero). clr wins over load; otherwise the
// count decrements toward zero and rests there.
module step_timer
    import stepper_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear, load, or decrement toward zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/stepper_seq.sv
// Stepper-motor phase sequencer fed by a 4-bit PIO command word.
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   cmd[3:0]        [0] enable, [1] direction (0 = forward), [3:2] rate (00 = hold)
//   coil[3:0]       registered coil drive pattern
//   step_pulse      one-cycle strobe on every phase advance
//   position        signed step count (two's complement, wraps)
//   running         high while in RUN or DEAD
// cmd is registered once; the FSM works from that copy and every output is
// registered, so a command change reaches the outputs two edges later.
module stepper_seq
    import stepper_pkg::*;
#(
    parameter int HALF_STEP = 0,
    parameter int DIV1      = 50000,
    parameter int DIV2      = 25000,
    parameter int DIV3      = 12500,
    parameter int DEAD_CYC  = 16,
    parameter int POS_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       cmd,
    output logic [3:0]       coil,
    output logic             step_pulse,
    output logic [POS_W-1:0] position,
    output logic             running
);

    localparam int MAX_A = (DIV1 > DIV2) ? DIV1 : DIV2;
    localparam int MAX_B = (MAX_A > DIV3) ? MAX_A : DIV3;
    localparam int MAX_V = (MAX_B > DEAD_CYC) ? MAX_B : DEAD_CYC;
    localparam int CNT_W = (MAX_V > 1) ? $clog2(MAX_V) : 1;

    localparam logic [CNT_W-1:0] DIV1_M1 = CNT_W'(DIV1 - 1);
    localparam logic [CNT_W-1:0] DIV2_M1 = CNT_W'(DIV2 - 1);
    localparam logic [CNT_W-1:0] DIV3_M1 = CNT_W'(DIV3 - 1);
    localparam logic [CNT_W-1:0] DEAD_M1 = CNT_W'((DEAD_CYC > 0) ? (DEAD_CYC - 1) : 0);
    localparam logic             HALF_L  = (HALF_STEP != 0);
    localparam logic [2:0]       IDX_LAST = HALF_L ? 3'd7 : 3'd3;

    logic [3:0]       cmd_q;
    state_e           state_d, state_q;
    logic [2:0]       idx_d, idx_q;
    logic             dir_d, dir_q;
    logic [POS_W-1:0] pos_d, pos_q;
    logic [3:0]       coil_d, coil_q;
    logic             pulse_d, pulse_q;
    logic             run_d, run_q;

    logic             en_s;
    logic             dir_cmd_s;
    logic [1:0]       rate_s;
    logic [CNT_W-1:0] div_m1_s;
    logic             step_s;
    logic             tmr_clr_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_tc_s;

    assign en_s      = cmd_q[0];
    assign dir_cmd_s = cmd_q[1];
    assign rate_s    = cmd_q[3:2];

    // Reload value for the rate currently commanded.
    always_comb begin
        div_m1_s = {CNT_W{1'b0}};
        case (rate_s)
            RATE_1:  div_m1_s = DIV1_M1;
            RATE_2:  div_m1_s = DIV2_M1;
            RATE_3:  div_m1_s = DIV3_M1;
            default: div_m1_s = {CNT_W{1'b0}};
        endcase
    end

    // Next-state logic. Priority: disable, then direction change, then terminal count.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        step_s     = 1'b0;
        tmr_clr_s  = 1'b0;
        tmr_load_s = 1'b0;
        tmr_val_s  = div_m1_s;
        case (state_q)
            IDLE: begin
                if (en_s) begin
                    dir_d = dir_cmd_s;
                    if (rate_s == RATE_HOLD) begin
                        state_d = HOLD;
                    end else begin
                        state_d    = RUN;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    tmr_clr_s = 1'b1;
                end
            end
            HOLD: begin
                if (!en_s) begin
                    state_d   = IDLE;
                    tmr_clr_s = 1'b1;
                end else begin
                    dir_d = dir_cmd_s;
                    if (rate_s != RATE_HOLD) begin
                        state_d    = RUN;
                        tmr_load_s = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            RUN: begin
                if (!en_s) begin
                    state_d   = IDLE;
                    tmr_clr_s = 1'b1;
                end else if (dir_cmd_s != dir_q) begin
                    if (DEAD_CYC == 0) begin
                        // No dead time: turn around and restart the period.
                        dir_d      = dir_cmd_s;
                        tmr_load_s = 1'b1;
                    end else begin
                        state_d    = DEAD;
                        tmr_load_s = 1'b1;
                        tmr_val_s  = DEAD_M1;
                    end
                end else if (tmr_tc_s) begin
                    if (rate_s == RATE_HOLD) begin
                        state_d = HOLD;
                    end else begin
                        // Rate is sampled only here, so a change never cuts a period short.
                        step_s     = 1'b1;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DEAD: begin
                if (!en_s) begin
                    state_d   = IDLE;
                    tmr_clr_s = 1'b1;
                end else if (tmr_tc_s) begin
                    dir_d = dir_cmd_s;
                    if (rate_s == RATE_HOLD) begin
                        state_d = HOLD;
                    end else begin
                        state_d    = RUN;
                        tmr_load_s = 1'b1;
                    end
                end else begin
                    state_d = DEAD;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_clr_s = 1'b1;
            end
        endcase
    end

    // Phase index and position advance on a step.
    always_comb begin
        idx_d = idx_q;
        pos_d = pos_q;
        if (step_s) begin
            if (dir_q == 1'b0) begin
                idx_d = (idx_q == IDX_LAST) ? 3'd0 : (idx_q + 3'd1);
                pos_d = pos_q + {{(POS_W-1){1'b0}}, 1'b1};
            end else begin
                idx_d = (idx_q == 3'd0) ? IDX_LAST : (idx_q - 3'd1);
                pos_d = pos_q - {{(POS_W-1){1'b0}}, 1'b1};
            end
        end else begin
            idx_d = idx_q;
            pos_d = pos_q;
        end
    end

    // Output values computed from the upcoming state so they register together.
    always_comb begin
        coil_d  = 4'b0000;
        run_d   = 1'b0;
        pulse_d = step_s;
        if ((state_d == HOLD) || (state_d == RUN)) begin
            coil_d = phase_coil(HALF_L, idx_d);
        end else begin
            coil_d = 4'b0000;
        end
        if ((state_d == RUN) || (state_d == DEAD)) begin
            run_d = 1'b1;
        end else begin
            run_d = 1'b0;
        end
    end

    // State, command and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q   <= 4'b0000;
            state_q <= IDLE;
            idx_q   <= 3'd0;
            dir_q   <= 1'b0;
            pos_q   <= {POS_W{1'b0}};
            coil_q  <= 4'b0000;
            pulse_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            cmd_q   <= cmd;
            state_q <= state_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            coil_q  <= coil_d;
            pulse_q <= pulse_d;
            run_q   <= run_d;
        end
    end

    step_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (tmr_clr_s),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .tc       (tmr_tc_s)
    );

    assign coil       = coil_q;
    assign step_pulse = pulse_q;
    assign position  = pos_q;
    assign running    = run_q;

endmodule

// File: tb/tb_stepper_seq.sv
// Bench for stepper_seq: a full-step instance and a half-step instance.
// Expected steps (coil, position, cycle) are queued when a command is driven
// and popped by a monitor whenever step_pulse is seen.
module tb_stepper_seq;

    typedef struct {
        logic [3:0]  coil;
        logic [15:0] pos;
        int          cyc;
    } step_t;

    logic        clk;
    logic        reset_n;
    logic        reset_n_h;
    logic [3:0]  cmd;
    logic [3:0]  cmd_h;
    logic [3:0]  coil,  coil_h;
    logic        step_pulse, step_pulse_h;
    logic [15:0] position, position_h;
    logic        running, running_h;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    step_t q_f[$];
    step_t q_h[$];
    step_t e_f;
    step_t e_h;

    stepper_seq #(.HALF_STEP(0), .DIV1(8), .DIV2(4), .DIV3(2), .DEAD_CYC(3), .POS_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .coil(coil),
        .step_pulse(step_pulse), .position(position), .running(running)
    );

    stepper_seq #(.HALF_STEP(1), .DIV1(8), .DIV2(4), .DIV3(2), .DEAD_CYC(3), .POS_W(16)) dut_h (
        .clk(clk), .reset_n(reset_n_h), .cmd(cmd_h), .coil(coil_h),
        .step_pulse(step_pulse_h), .position(position_h), .running(running_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_f(input logic [3:0] c, input logic [15:0] p, input int cy);
        step_t s;
        s.coil = c; s.pos = p; s.cyc = cy;
        q_f.push_back(s);
    endtask

    task automatic push_h(input logic [3:0] c, input logic [15:0] p, input int cy);
        step_t s;
        s.coil = c; s.pos = p; s.cyc = cy;
        q_h.push_back(s);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cmd     = 4'b0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Scoreboard for the full-step instance.
    always @(negedge clk) begin
        if (step_pulse === 1'b1) begin
            if (q_f.size() == 0) begin
                check_eq("f_unexpected_step", 32'(step_pulse), 32'd0);
            end else begin
                e_f = q_f.pop_front();
                check_eq("f_step_coil", 32'(coil), 32'(e_f.coil));
                check_eq("f_step_pos", 32'(position), 32'(e_f.pos));
                check_eq("f_step_cycle", 32'(cyc), 32'(e_f.cyc));
            end
        end
    end

    // Scoreboard for the half-step instance.
    always @(negedge clk) begin
        if (step_pulse_h === 1'b1) begin
            if (q_h.size() == 0) begin
                check_eq("h_unexpected_step", 32'(step_pulse_h), 32'd0);
            end else begin
                e_h = q_h.pop_front();
                check_eq("h_step_coil", 32'(coil_h), 32'(e_h.coil));
                check_eq("h_step_pos", 32'(position_h), 32'(e_h.pos));
                check_eq("h_step_cycle", 32'(cyc), 32'(e_h.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n   = 1'b0;
        reset_n_h = 1'b0;
        cmd       = 4'b0000;
        cmd_h     = 4'b0000;
        repeat (3) @(negedge clk);

        // Reset values, then idle with cmd = 0.
        check_eq("rst_coil", 32'(coil), 32'h0);
        check_eq("rst_pos", 32'(position), 32'h0);
        check_eq("rst_running", 32'(running), 32'h0);
        check_eq("rst_pulse", 32'(step_pulse), 32'h0);
        reset_n = 1'b1;
        t = cyc;
        wait_to(t + 10);
        check_eq("idle_coil", 32'(coil), 32'h0);
        check_eq("idle_pos", 32'(position), 32'h0);
        check_eq("idle_running", 32'(running), 32'h0);

        // Forward at rate 11: a step every 2 cycles, then disable on a terminal count.
        do_reset();
        t = cyc;
        cmd = 4'b1101;
        push_f(4'b0110, 16'd1, t + 4);
        push_f(4'b1100, 16'd2, t + 6);
        push_f(4'b1001, 16'd3, t + 8);
        push_f(4'b0011, 16'd4, t + 10);
        wait_to(t + 1);
        check_eq("fwd_latency_coil", 32'(coil), 32'h0);
        wait_to(t + 2);
        check_eq("fwd_start_coil", 32'(coil), 32'h3);
        check_eq("fwd_start_running", 32'(running), 32'h1);
        wait_to(t + 10);
        cmd = 4'b0000;
        wait_to(t + 12);
        check_eq("dis_coil", 32'(coil), 32'h0);
        check_eq("dis_running", 32'(running), 32'h0);
        check_eq("dis_pos", 32'(position), 32'd4);
        wait_to(t + 16);
        check_eq("fwd_queue_empty", 32'(q_f.size()), 32'd0);

        // Reversal at rate 01: three dead cycles, then reverse steps through the wrap.
        do_reset();
        t = cyc;
        cmd = 4'b0101;
        push_f(4'b0110, 16'd1, t + 10);
        push_f(4'b0011, 16'd0, t + 26);
        push_f(4'b1001, 16'hFFFF, t + 34);
        push_f(4'b1100, 16'hFFFE, t + 42);
        wait_to(t + 13);
        cmd = 4'b0111;
        wait_to(t + 14);
        check_eq("rev_pre_dead_coil", 32'(coil), 32'h6);
        wait_to(t + 15);
        check_eq("dead1_coil", 32'(coil), 32'h0);
        check_eq("dead1_running", 32'(running), 32'h1);
        wait_to(t + 16);
        check_eq("dead2_coil", 32'(coil), 32'h0);
        wait_to(t + 17);
        check_eq("dead3_coil", 32'(coil), 32'h0);
        wait_to(t + 18);
        check_eq("rev_resume_coil", 32'(coil), 32'h6);
        wait_to(t + 46);
        check_eq("rev_queue_empty", 32'(q_f.size()), 32'd0);

        // Rate 01 -> 10 mid-period: current period completes, then every 4 cycles.
        do_reset();
        t = cyc;
        cmd = 4'b0101;
        push_f(4'b0110, 16'd1, t + 10);
        push_f(4'b1100, 16'd2, t + 14);
        push_f(4'b1001, 16'd3, t + 18);
        push_f(4'b0011, 16'd4, t + 22);
        wait_to(t + 5);
        cmd = 4'b1001;
        wait_to(t + 25);
        check_eq("rate_queue_empty", 32'(q_f.size()), 32'd0);

        // Hold after 5 steps, disable, re-enable hold.
        do_reset();
        t = cyc;
        cmd = 4'b1101;
        push_f(4'b0110, 16'd1, t + 4);
        push_f(4'b1100, 16'd2, t + 6);
        push_f(4'b1001, 16'd3, t + 8);
        push_f(4'b0011, 16'd4, t + 10);
        push_f(4'b0110, 16'd5, t + 12);
        wait_to(t + 12);
        cmd = 4'b0001;
        wait_to(t + 14);
        check_eq("hold_coil", 32'(coil), 32'h6);
        check_eq("hold_running", 32'(running), 32'h0);
        wait_to(t + 20);
        check_eq("hold_coil_late", 32'(coil), 32'h6);
        check_eq("hold_pos", 32'(position), 32'd5);
        cmd = 4'b0000;
        wait_to(t + 22);
        check_eq("hold_off_coil", 32'(coil), 32'h0);
        check_eq("hold_off_pos", 32'(position), 32'd5);
        cmd = 4'b0001;
        wait_to(t + 24);
        check_eq("rehold_coil", 32'(coil), 32'h6);
        check_eq("rehold_pos", 32'(position), 32'd5);
        check_eq("hold_queue_empty", 32'(q_f.size()), 32'd0);

        // Half-step, reverse, rate 11, reset asserted mid-period.
        reset_n_h = 1'b1;
        t = cyc;
        cmd_h = 4'b1111;
        push_h(4'b1001, 16'hFFFF, t + 4);
        push_h(4'b1000, 16'hFFFE, t + 6);
        wait_to(t + 2);
        check_eq("half_start_coil", 32'(coil_h), 32'h1);
        wait_to(t + 7);
        reset_n_h = 1'b0;
        #1;
        check_eq("half_rst_coil", 32'(coil_h), 32'h0);
        check_eq("half_rst_pos", 32'(position_h), 32'h0);
        check_eq("half_rst_running", 32'(running_h), 32'h0);
        check_eq("half_rst_pulse", 32'(step_pulse_h), 32'h0);
        wait_to(t + 12);
        check_eq("half_queue_empty", 32'(q_h.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
